// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Digit-serial adder, DIGIT bits per clock, start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int C_N  = WIDTH / DIGIT;
    localparam int C_CW = (C_N > 1) ? $clog2(C_N) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [C_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_opa;
    logic [WIDTH-1:0]  r_opb;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;
    logic              r_amsb;
    logic              r_bmsb;
    logic              r_busy;
    logic              r_done;
    logic              r_cout;
    logic              r_ovf;

    logic [DIGIT:0]    w_slice;
    logic [WIDTH-1:0]  w_slice_top;
    logic [WIDTH-1:0]  w_acc_next;

    // One DIGIT-wide full-adder slice, reused every RUN cycle.
    assign w_slice     = {1'b0, r_opa[DIGIT-1:0]} + {1'b0, r_opb[DIGIT-1:0]}
                       + {{DIGIT{1'b0}}, r_carry};
    assign w_slice_top = WIDTH'(w_slice[DIGIT-1:0]) << (WIDTH - DIGIT);
    // New digits enter at the MSB end so the last slice lands in place.
    assign w_acc_next  = (r_acc >> DIGIT) | w_slice_top;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_amsb  <= 1'b0;
            r_bmsb  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opa   <= a;
                        r_opb   <= b;
                        r_carry <= cin;
                        r_amsb  <= a[WIDTH-1];
                        r_bmsb  <= b[WIDTH-1];
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_opa   <= r_opa >> DIGIT;
                    r_opb   <= r_opb >> DIGIT;
                    r_carry <= w_slice[DIGIT];
                    r_acc   <= w_acc_next;
                    r_cnt   <= r_cnt + C_CW'(1);
                    if (r_cnt == C_CW'(C_N - 1)) begin
                        r_sum   <= w_acc_next;
                        r_cout  <= w_slice[DIGIT];
                        r_ovf   <= (r_amsb == r_bmsb) && (w_acc_next[WIDTH-1] != r_amsb);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder. It computes the WIDTH-bit sum a + b + cin by processing DIGIT bits per clock with a registered carry, using a start/busy/done handshake. It is the sequential, width-generic successor to the team's single-bit dataflow full adder: one DIGIT-wide full-adder slice is reused over WIDTH/DIGIT cycles, trading latency for area. It sits between operand registers and any consumer that can wait for a done pulse.

## Interface
Parameters:
- WIDTH, default 8: operand and sum width in bits; must be ≥ 2.
- DIGIT, default 1: bits added per cycle; must satisfy 1 ≤ DIGIT ≤ WIDTH and WIDTH % DIGIT == 0. Define N = WIDTH/DIGIT.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request a new addition; sampled only while busy = 0.
- a, input, WIDTH: operand A; sampled on the accepting edge only.
- b, input, WIDTH: operand B; sampled on the accepting edge only.
- cin, input, 1: carry-in; sampled on the accepting edge only.
- busy, output, 1: high while an addition is in progress.
- done, output, 1: one-cycle pulse marking that sum, cout and overflow are valid.
- sum, output, WIDTH: result; updated only on completion and held until the next completion.
- cout, output, 1: carry out of the MSB.
- overflow, output, 1: two's-complement signed overflow.

## Operation
- FSM states are IDLE and RUN. A digit counter cnt spans 0..N-1, with width max(1, clog2(N)).
- In IDLE with start = 1 on an edge:
  - latch a, b and cin into the operand shift registers and the carry register;
  - set cnt to 0;
  - set busy to 1 and go to RUN.
- In IDLE with start = 0, nothing changes.
- In RUN, on each edge:
  - add the low DIGIT bits of the A and B shift registers plus the carry register;
  - shift the DIGIT-bit result into the MSB end of the partial-sum register, and shift both operand registers right by DIGIT;
  - store the slice carry into the carry register;
  - increment cnt.
- On the RUN edge where cnt = N-1:
  - write the completed value into sum and the slice carry into cout;
  - compute overflow = (A_msb == B_msb) && (sum_msb != A_msb), using the latched operand MSBs saved at acceptance;
  - set done to 1, set busy to 0, and go to IDLE.
- done is set for exactly one cycle and cleared on the following edge.
- start while busy = 1 is ignored. Changes on a, b or cin during RUN have no effect.
- Arithmetic is unsigned modulo 2^WIDTH, with cout as the extra bit. The result equals {cout, sum} = a + b + cin exactly.

## Timing
- Reset (rst_n low, asynchronous): state goes to IDLE, and busy, done, sum, cout, overflow, cnt and all internal registers go to 0. Outputs reach 0 without waiting for a clock edge.
- Latency: if start is accepted on edge k, busy is high from edge k to edge k+N. Result and done appear at edge k+N, so the latency is N clock edges.
- busy falls and done rises on the same edge.
- The earliest next acceptance is edge k+N+1, because start is sampled while done = 1 and busy = 0. Holding start high continuously gives one result every N+1 cycles.
- Reset asserted mid-RUN aborts the operation:
  - no done pulse is produced;
  - sum, cout and overflow read 0 afterwards;
  - the first start after rst_n deasserts is accepted normally.
- DIGIT = WIDTH (N = 1): the block behaves as a registered adder with latency 1 and a throughput of one result every 2 cycles.
- sum, cout and overflow are stable from the done edge until the next done edge or reset. They never show partial values.

## Test plan
- Wrap, with WIDTH=8, DIGIT=1: a=8'hFF, b=8'h01, cin=0 gives sum=8'h00, cout=1, overflow=0. done pulses for exactly one cycle, 8 edges after the accepting edge, and busy is high for exactly 8 cycles.
- Signed overflow, with WIDTH=8, DIGIT=1: a=8'h7F, b=8'h01, cin=0 gives sum=8'h80, cout=0, overflow=1. Also a=8'h80, b=8'h80 gives sum=8'h00, cout=1, overflow=1.
- Exhaustive sweep, with WIDTH=4, DIGIT=1 and DIGIT=2: all 512 combinations of a, b and cin, checked against {cout, sum} = a+b+cin. Latency must be 4 and 2 edges respectively, and no mismatches are allowed.
- Wide digit and back-to-back, with WIDTH=8, DIGIT=4: a=8'hA5, b=8'h5A, cin=1 gives sum=8'h00, cout=1, done 2 edges after start. With start held high, a second operation a=8'h12, b=8'h34, cin=0 is accepted at edge k+3 and gives sum=8'h46.
- Protocol robustness: pulse start again and change a/b to 8'hFF during RUN. The original result is still produced, only one done pulse occurs, and the extra start is ignored.
- Reset mid-op: assert rst_n low at cycle 3 of an 8-cycle run. Outputs read 0 immediately and no done pulse occurs. After release, 8'h03+8'h04 gives sum=8'h07 with normal latency.
